// File: rtl/matvec_loader.sv
// Serial-to-parallel operand loader: assembles vectors a and b from a framed
// valid/ready word stream and holds them stable until the adder acknowledges.
module matvec_loader #(
    parameter int WIDTH = 32,
    parameter int LEN   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [WIDTH-1:0] in_data_i,
    input  logic                    in_last_i,
    output logic signed [WIDTH-1:0] a_vec_o [LEN],
    output logic signed [WIDTH-1:0] b_vec_o [LEN],
    output logic                    vec_valid_o,
    input  logic                    vec_ack_i,
    output logic                    frame_err_o
);

    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    vec_valid_q, vec_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic signed [WIDTH-1:0] a_q [LEN];
    logic signed [WIDTH-1:0] b_q [LEN];

    logic xfer;
    logic at_frame_end;
    logic framing_bad;
    logic wr_a;
    logic wr_b;

    // in_ready is a pure function of state and reset so it never waits on in_valid.
    assign in_ready_o   = !rst && (state_q != S_HOLD);
    assign xfer         = in_valid_i && in_ready_o;
    assign at_frame_end = (state_q == S_LOAD_B) && (idx_q == IDX_LAST);
    assign framing_bad  = xfer && (in_last_i != at_frame_end);

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_err_d = 1'b0;
        wr_a        = 1'b0;
        wr_b        = 1'b0;

        unique case (state_q)
            S_LOAD_A, S_LOAD_B: begin
                if (framing_bad) begin
                    // Drop the frame: the offending word is not stored.
                    state_d     = S_LOAD_A;
                    idx_d       = '0;
                    frame_err_d = 1'b1;
                end else if (xfer) begin
                    wr_a = (state_q == S_LOAD_A);
                    wr_b = (state_q == S_LOAD_B);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_HOLD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (vec_ack_i) begin
                    state_d = S_LOAD_A;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_LOAD_A;
                idx_d   = '0;
            end
        endcase

        vec_valid_d = (state_d == S_HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD_A;
            idx_q       <= '0;
            vec_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            // NOTE: the operand arrays are reset because their contents are
            // visible on the ports; a scratch buffer would not need this.
            for (int i = 0; i < LEN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_valid_q <= vec_valid_d;
            frame_err_q <= frame_err_d;
            if (wr_a) a_q[idx_q] <= in_data_i;
            if (wr_b) b_q[idx_q] <= in_data_i;
        end
    end

    assign a_vec_o     = a_q;
    assign b_vec_o     = b_q;
    assign vec_valid_o = vec_valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_matvec_loader.sv
// Directed self-checking bench for matvec_loader: reset, framing, backpressure,
// bubbles with extreme data, and mid-frame reset.
module tb_matvec_loader;

    localparam int WIDTH = 32;
    localparam int LEN   = 5;
    localparam logic signed [WIDTH-1:0] MAXV = 32'sh7FFF_FFFF;
    localparam logic signed [WIDTH-1:0] MINV = 32'sh8000_0000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic signed [WIDTH-1:0] a_vec [LEN];
    logic signed [WIDTH-1:0] b_vec [LEN];
    logic                    vec_valid;
    logic                    vec_ack;
    logic                    frame_err;

    int errors = 0;
    int checks = 0;
    logic signed [WIDTH-1:0] exp_a [LEN];
    logic signed [WIDTH-1:0] exp_b [LEN];

    matvec_loader #(.WIDTH(WIDTH), .LEN(LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .a_vec_o    (a_vec),
        .b_vec_o    (b_vec),
        .vec_valid_o(vec_valid),
        .vec_ack_i  (vec_ack),
        .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        vec_ack = 1'b0;
        drive(1'b1, 32'h5555_AAAA, 1'b0);
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        checks++;
        if (vec_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got vec_valid=%b frame_err=%b expected 0/0", vec_valid, frame_err);
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (a_vec[i] !== '0 || b_vec[i] !== '0) begin
                errors++;
                $display("FAIL reset_vec[%0d]: got a=%h b=%h expected 0/0", i, a_vec[i], b_vec[i]);
            end
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_normal_frame();
        logic signed [WIDTH-1:0] w [10];
        logic signed [WIDTH-1:0] sums [LEN];
        logic signed [WIDTH-1:0] s;
        w    = '{1, 2, 3, 4, 5, 10, 20, 30, 40, -5};
        sums = '{11, 22, 33, 44, 0};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, w[i], i == 9);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL normal_in_ready word %0d: got %b expected 1", i, in_ready);
            end
            tick();
            if (i < 9) begin
                checks++;
                if (vec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL normal_early_valid after word %0d: got %b expected 0", i, vec_valid);
                end
            end
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (vec_valid !== 1'b1 || in_ready !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL normal_hold: got valid=%b ready=%b err=%b expected 1/0/0", vec_valid, in_ready, frame_err);
        end
        for (int i = 0; i < LEN; i++) begin
            exp_a[i] = w[i];
            exp_b[i] = w[i+LEN];
            checks++;
            if (a_vec[i] !== exp_a[i] || b_vec[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL normal_vec[%0d]: got a=%0d b=%0d expected %0d/%0d", i, a_vec[i], b_vec[i], exp_a[i], exp_b[i]);
            end
            s = a_vec[i] + b_vec[i];
            checks++;
            if (s !== sums[i]) begin
                errors++;
                $display("FAIL normal_sum[%0d]: got %0d expected %0d", i, s, sums[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h0BAD_F00D, 1'b0);
        vec_ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || vec_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall cycle %0d: got ready=%b valid=%b expected 0/1", c, in_ready, vec_valid);
            end
        end
        drive(1'b0, '0, 1'b0);
        vec_ack = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ack_cycle_ready: got %b expected 0", in_ready);
        end
        tick();
        vec_ack = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_ack: got ready=%b valid=%b expected 1/0", in_ready, vec_valid);
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (a_vec[i] !== exp_a[i] || b_vec[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL bp_vec_stable[%0d]: got a=%h b=%h expected %h/%h", i, a_vec[i], b_vec[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_early_last();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, WIDTH'(100 + i), i == 3);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_err_pulse: got err=%b valid=%b expected 1/0", frame_err, vec_valid);
        end
        for (int i = 0; i < 3; i++) exp_a[i] = WIDTH'(100 + i);
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (a_vec[i] !== exp_a[i] || b_vec[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL early_vec[%0d]: got a=%0d b=%0d expected %0d/%0d", i, a_vec[i], b_vec[i], exp_a[i], exp_b[i]);
            end
        end
        tick();
        checks++;
        if (frame_err !== 1'b0 || vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_err_one_cycle: got err=%b valid=%b expected 0/0", frame_err, vec_valid);
        end
        // Recovery frame with vec_ack asserted throughout loading.
        vec_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, WIDTH'(11 + i), i == 9);
            tick();
            if (i < 9) begin
                checks++;
                if (vec_valid !== 1'b0 || frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL early_recover word %0d: got valid=%b err=%b expected 0/0", i, vec_valid, frame_err);
                end
            end
        end
        vec_ack = 1'b0;
        drive(1'b0, '0, 1'b0);
        checks++;
        if (vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL early_recover_hold: got %b expected 1", vec_valid);
        end
        for (int i = 0; i < LEN; i++) begin
            exp_a[i] = WIDTH'(11 + i);
            exp_b[i] = WIDTH'(16 + i);
            checks++;
            if (a_vec[i] !== exp_a[i] || b_vec[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL early_recover_vec[%0d]: got a=%0d b=%0d expected %0d/%0d", i, a_vec[i], b_vec[i], exp_a[i], exp_b[i]);
            end
        end
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
    endtask

    task automatic test_missing_last();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, WIDTH'(200 + i), 1'b0);
            tick();
            if (i < 9) begin
                checks++;
                if (frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL missing_premature_err word %0d: got %b expected 0", i, frame_err);
                end
            end
        end
        checks++;
        if (frame_err !== 1'b1 || vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL missing_err_pulse: got err=%b valid=%b expected 1/0", frame_err, vec_valid);
        end
        for (int i = 0; i < LEN; i++) exp_a[i] = WIDTH'(200 + i);
        for (int i = 0; i < LEN - 1; i++) exp_b[i] = WIDTH'(205 + i);
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (a_vec[i] !== exp_a[i] || b_vec[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL missing_vec[%0d]: got a=%0d b=%0d expected %0d/%0d", i, a_vec[i], b_vec[i], exp_a[i], exp_b[i]);
            end
        end
        drive(1'b1, WIDTH'(300), 1'b0);
        tick();
        checks++;
        if (a_vec[0] !== 32'sd300 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL missing_11th_word: got a0=%0d err=%b expected 300/0", a_vec[0], frame_err);
        end
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, WIDTH'(300 + i), i == 9);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL missing_next_hold: got %b expected 1", vec_valid);
        end
        for (int i = 0; i < LEN; i++) begin
            exp_a[i] = WIDTH'(300 + i);
            exp_b[i] = WIDTH'(305 + i);
            checks++;
            if (a_vec[i] !== exp_a[i] || b_vec[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL missing_next_vec[%0d]: got a=%0d b=%0d expected %0d/%0d", i, a_vec[i], b_vec[i], exp_a[i], exp_b[i]);
            end
        end
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
    endtask

    task automatic test_bubbles_reset();
        logic signed [WIDTH-1:0] w [10];
        w = '{MAXV, MINV, MINV, MAXV, MAXV, MINV, MAXV, MINV, MINV, MAXV};
        for (int i = 0; i < 10; i++) begin
            for (int g = 0; g < i % 3; g++) begin
                drive(1'b0, 32'hDEAD_BEEF, 1'b1);
                tick();
                checks++;
                if (frame_err !== 1'b0 || vec_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble_gap word %0d: got err=%b valid=%b expected 0/0", i, frame_err, vec_valid);
                end
            end
            drive(1'b1, w[i], i == 9);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (vec_valid !== 1'b1) begin
            errors++;
            $display("FAIL bubble_hold: got %b expected 1", vec_valid);
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (a_vec[i] !== w[i] || b_vec[i] !== w[i+LEN]) begin
                errors++;
                $display("FAIL bubble_vec[%0d]: got a=%h b=%h expected %h/%h", i, a_vec[i], b_vec[i], w[i], w[i+LEN]);
            end
        end
        vec_ack = 1'b1;
        tick();
        vec_ack = 1'b0;
        // Partial frame of seven words, then reset.
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 1) begin
                drive(1'b0, 32'hDEAD_BEEF, 1'b0);
                tick();
            end
            drive(1'b1, w[9-i], 1'b0);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 32'h0F0F_0F0F, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (vec_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got valid=%b err=%b expected 0/0", vec_valid, frame_err);
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (a_vec[i] !== '0 || b_vec[i] !== '0) begin
                errors++;
                $display("FAIL midreset_vec[%0d]: got a=%h b=%h expected 0/0", i, a_vec[i], b_vec[i]);
            end
        end
        rst = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release_ready: got %b expected 1", in_ready);
        end
        tick();
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < LEN; i++) begin
            exp_a[i] = (i == 0) ? 32'sh1234_5678 : '0;
            checks++;
            if (a_vec[i] !== exp_a[i] || b_vec[i] !== '0) begin
                errors++;
                $display("FAIL midreset_restart_vec[%0d]: got a=%h b=%h expected %h/0", i, a_vec[i], b_vec[i], exp_a[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_bubbles_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
